// File: rtl/sc_session_pkg.sv
// rtl/sc_session_pkg.sv - shared state encoding and default timing for the smartcard session controller
// Ports: none (package).
package sc_session_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_T_PWR   = 256;
  localparam int DEF_T_RST   = 512;
  localparam int DEF_ATR_MIN = 400;
  localparam int DEF_ATR_MAX = 40000;
  localparam int DEF_T_STEP  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PWR    = 3'd1,
    ST_CLKON  = 3'd2,
    ST_ATRW   = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_DEACT  = 3'd5
  } state_e;

endpackage

// File: rtl/sc_session_ctrl_if.sv
// rtl/sc_session_ctrl_if.sv - host control and card pin bundle for the session controller
// Ports: none; signals card_inserted/start_i/stop_i/io_i (to controller),
//        card_power_en/card_oe/card_clk_en/card_rst/io_grant/active/err_timeout/err_removed/state_o (from controller).
interface sc_session_ctrl_if;

  logic       card_inserted;
  logic       start_i;
  logic       stop_i;
  logic       io_i;
  logic       card_power_en;
  logic       card_oe;
  logic       card_clk_en;
  logic       card_rst;
  logic       io_grant;
  logic       active;
  logic       err_timeout;
  logic       err_removed;
  logic [2:0] state_o;

  modport slave (
    input  card_inserted, start_i, stop_i, io_i,
    output card_power_en, card_oe, card_clk_en, card_rst,
           io_grant, active, err_timeout, err_removed, state_o
  );

  modport master (
    output card_inserted, start_i, stop_i, io_i,
    input  card_power_en, card_oe, card_clk_en, card_rst,
           io_grant, active, err_timeout, err_removed, state_o
  );

endinterface

// File: rtl/sc_sync_edge.sv
// rtl/sc_sync_edge.sv - 2-flop synchroniser with registered falling-edge pulse
// Ports: clk, rst (async, active-high), async_i (raw pin), level_o (synced level),
//        fall_o (one-cycle pulse, 3 cycles after the pin falls).
module sc_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = async_i;
    s2_d   = s1_q;
    prev_d = s2_q;
    fall_d = prev_q & ~s2_q;
  end

  // Reset to the idle level so no spurious edge appears after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = s2_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sc_session_ctrl.sv
// rtl/sc_session_ctrl.sv - smartcard cold activation, ATR detection and deactivation sequencer
// Ports: clk (card clock), rst (async, active-high), bus (sc_session_ctrl_if.slave: host
//        start/stop, card switch and I/O in; rail enables, card reset, I/O grant, status out).
module sc_session_ctrl
  import sc_session_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int T_PWR   = DEF_T_PWR,
  parameter int T_RST   = DEF_T_RST,
  parameter int ATR_MIN = DEF_ATR_MIN,
  parameter int ATR_MAX = DEF_ATR_MAX,
  parameter int T_STEP  = DEF_T_STEP
) (
  input  logic               clk,
  input  logic               rst,
  sc_session_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] ATR_LO     = CNT_W'(ATR_MIN);
  localparam logic [CNT_W-1:0] ATR_LAST   = CNT_W'(ATR_MAX - 1);
  localparam logic [CNT_W-1:0] STEP_CLK   = CNT_W'(T_STEP);
  localparam logic [CNT_W-1:0] STEP_OE    = CNT_W'(2 * T_STEP);
  localparam logic [CNT_W-1:0] DEACT_LAST = CNT_W'(3 * T_STEP - 1);

  logic io_fall;
  logic ins_level;

  sc_sync_edge #(.RST_VAL(1'b1)) u_io_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.io_i),
    .level_o (),
    .fall_o  (io_fall)
  );

  sc_sync_edge #(.RST_VAL(1'b0)) u_ins_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.card_inserted),
    .level_o (ins_level),
    .fall_o  ()
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             card_power_en_q, card_power_en_d;
  logic             card_oe_q, card_oe_d;
  logic             card_clk_en_q, card_clk_en_d;
  logic             card_rst_q, card_rst_d;
  logic             io_grant_q, io_grant_d;
  logic             active_q, active_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_removed_q, err_removed_d;
  logic             removal;

  // Card gone while a session is being built or held; IDLE and DEACT already head to power-off.
  assign removal = ~ins_level && (state_q != ST_IDLE) && (state_q != ST_DEACT);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    err_removed_d = err_removed_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && ins_level) begin
          state_d       = ST_PWR;
          err_timeout_d = 1'b0;
          err_removed_d = 1'b0;
        end
      end
      ST_PWR: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.stop_i)            state_d = ST_DEACT;
        else if (cnt_q == PWR_LAST) state_d = ST_CLKON;
      end
      ST_CLKON: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.stop_i)            state_d = ST_DEACT;
        else if (cnt_q == RST_LAST) state_d = ST_ATRW;
      end
      ST_ATRW: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.stop_i) begin
          state_d = ST_DEACT;
        end else if (io_fall && (cnt_q >= ATR_LO)) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q == ATR_LAST) begin
          state_d       = ST_DEACT;
          err_timeout_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (bus.stop_i) state_d = ST_DEACT;
      end
      ST_DEACT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DEACT_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_DEACT;
    endcase

    if (removal) begin
      state_d       = ST_DEACT;
      err_removed_d = 1'b1;
    end

    // Every state entry restarts the shared delay counter.
    if (state_d != state_q) cnt_d = '0;
  end

  // Pin outputs are registered from the upcoming state/count so they move with the state.
  always_comb begin
    card_power_en_d = 1'b0;
    card_oe_d       = 1'b0;
    card_clk_en_d   = 1'b0;
    card_rst_d      = 1'b1;
    io_grant_d      = 1'b0;
    active_d        = 1'b0;
    case (state_d)
      ST_PWR: begin
        card_power_en_d = 1'b1;
        card_oe_d       = 1'b1;
      end
      ST_CLKON: begin
        card_power_en_d = 1'b1;
        card_oe_d       = 1'b1;
        card_clk_en_d   = 1'b1;
      end
      ST_ATRW: begin
        card_power_en_d = 1'b1;
        card_oe_d       = 1'b1;
        card_clk_en_d   = 1'b1;
        card_rst_d      = 1'b0;
      end
      ST_ACTIVE: begin
        card_power_en_d = 1'b1;
        card_oe_d       = 1'b1;
        card_clk_en_d   = 1'b1;
        card_rst_d      = 1'b0;
        io_grant_d      = 1'b1;
        active_d        = 1'b1;
      end
      ST_DEACT: begin
        // Rails only ever switch off here, so an abort from PWR never starts the clock.
        card_power_en_d = card_power_en_q;
        card_oe_d       = card_oe_q & (cnt_d < STEP_OE);
        card_clk_en_d   = card_clk_en_q & (cnt_d < STEP_CLK);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      card_power_en_q <= 1'b0;
      card_oe_q       <= 1'b0;
      card_clk_en_q   <= 1'b0;
      card_rst_q      <= 1'b1;
      io_grant_q      <= 1'b0;
      active_q        <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_removed_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      card_power_en_q <= card_power_en_d;
      card_oe_q       <= card_oe_d;
      card_clk_en_q   <= card_clk_en_d;
      card_rst_q      <= card_rst_d;
      io_grant_q      <= io_grant_d;
      active_q        <= active_d;
      err_timeout_q   <= err_timeout_d;
      err_removed_q   <= err_removed_d;
    end
  end

  // Removal overrides reset and I/O ownership in the same cycle it is seen.
  assign bus.card_power_en = card_power_en_q;
  assign bus.card_oe       = card_oe_q;
  assign bus.card_clk_en   = card_clk_en_q;
  assign bus.card_rst      = card_rst_q | removal;
  assign bus.io_grant      = io_grant_q & ~removal;
  assign bus.active        = active_q & ~removal;
  assign bus.err_timeout   = err_timeout_q;
  assign bus.err_removed   = err_removed_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_sc_session_ctrl.sv
// tb/tb_sc_session_ctrl.sv - directed self-checking bench for sc_session_ctrl
module tb_sc_session_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sc_session_ctrl_if bus ();

  sc_session_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at cycle +1 relative to the request.
  task automatic pulse_start;
    bus.start_i = 1'b1;
    step(1);
    bus.start_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst               = 1'b1;
    bus.card_inserted = 1'b0;
    bus.io_i          = 1'b1;
    bus.start_i       = 1'b0;
    bus.stop_i        = 1'b0;
    step(3);

    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_pwr", 32'(bus.card_power_en), 0);
    chk("rst_oe", 32'(bus.card_oe), 0);
    chk("rst_clk", 32'(bus.card_clk_en), 0);
    chk("rst_card_rst", 32'(bus.card_rst), 1);
    chk("rst_grant", 32'(bus.io_grant), 0);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_err_to", 32'(bus.err_timeout), 0);
    chk("rst_err_rm", 32'(bus.err_removed), 0);

    // Normal activation, ATR 1000 cycles after reset release.
    rst = 1'b0;
    bus.card_inserted = 1'b1;
    step(4);
    pulse_start();
    chk("act_pwr_p1", 32'(bus.card_power_en), 1);
    chk("act_oe_p1", 32'(bus.card_oe), 1);
    chk("act_state_p1", 32'(bus.state_o), 1);
    chk("act_clk_p1", 32'(bus.card_clk_en), 0);
    step(255);
    chk("act_clk_p256", 32'(bus.card_clk_en), 0);
    step(1);
    chk("act_clk_p257", 32'(bus.card_clk_en), 1);
    chk("act_state_p257", 32'(bus.state_o), 2);
    step(511);
    chk("act_rst_p768", 32'(bus.card_rst), 1);
    step(1);
    chk("act_rst_p769", 32'(bus.card_rst), 0);
    chk("act_state_p769", 32'(bus.state_o), 3);
    step(1000);
    bus.io_i = 1'b0;
    step(3);
    chk("act_active_e3", 32'(bus.active), 0);
    step(1);
    chk("act_active_e4", 32'(bus.active), 1);
    chk("act_grant_e4", 32'(bus.io_grant), 1);
    chk("act_state_e4", 32'(bus.state_o), 4);
    bus.io_i = 1'b1;

    // Host stop from ACTIVE: ordered deactivation from DEACT entry.
    step(5);
    bus.stop_i = 1'b1;
    step(1);
    bus.stop_i = 1'b0;
    chk("stop_state_e", 32'(bus.state_o), 5);
    chk("stop_rst_e", 32'(bus.card_rst), 1);
    chk("stop_grant_e", 32'(bus.io_grant), 0);
    chk("stop_active_e", 32'(bus.active), 0);
    chk("stop_clk_e", 32'(bus.card_clk_en), 1);
    step(15);
    chk("stop_clk_e15", 32'(bus.card_clk_en), 1);
    step(1);
    chk("stop_clk_e16", 32'(bus.card_clk_en), 0);
    chk("stop_oe_e16", 32'(bus.card_oe), 1);
    step(16);
    chk("stop_oe_e32", 32'(bus.card_oe), 0);
    chk("stop_pwr_e32", 32'(bus.card_power_en), 1);
    step(15);
    chk("stop_pwr_e47", 32'(bus.card_power_en), 1);
    chk("stop_state_e47", 32'(bus.state_o), 5);
    step(1);
    chk("stop_pwr_e48", 32'(bus.card_power_en), 0);
    chk("stop_state_e48", 32'(bus.state_o), 0);

    // start_i with no card is ignored.
    bus.card_inserted = 1'b0;
    step(3);
    pulse_start();
    step(1);
    chk("nocard_state", 32'(bus.state_o), 0);
    chk("nocard_pwr", 32'(bus.card_power_en), 0);

    // No ATR: timeout at release+40000, then deactivation.
    bus.card_inserted = 1'b1;
    step(3);
    pulse_start();
    step(768);
    chk("to_state_rel", 32'(bus.state_o), 3);
    step(39999);
    chk("to_err_pre", 32'(bus.err_timeout), 0);
    chk("to_state_pre", 32'(bus.state_o), 3);
    step(1);
    chk("to_err", 32'(bus.err_timeout), 1);
    chk("to_state", 32'(bus.state_o), 5);
    chk("to_card_rst", 32'(bus.card_rst), 1);
    step(16);
    chk("to_clk_16", 32'(bus.card_clk_en), 0);
    chk("to_rst_16", 32'(bus.card_rst), 1);
    step(16);
    chk("to_oe_32", 32'(bus.card_oe), 0);
    chk("to_rst_32", 32'(bus.card_rst), 1);
    step(16);
    chk("to_state_48", 32'(bus.state_o), 0);
    chk("to_pwr_48", 32'(bus.card_power_en), 0);
    chk("to_err_sticky", 32'(bus.err_timeout), 1);

    // Early glitch ignored, ATR at release+500 accepted.
    pulse_start();
    chk("gl_err_clr", 32'(bus.err_timeout), 0);
    chk("gl_state_p1", 32'(bus.state_o), 1);
    step(768);
    step(100);
    bus.io_i = 1'b0;
    step(2);
    bus.io_i = 1'b1;
    step(8);
    chk("gl_state_110", 32'(bus.state_o), 3);
    step(390);
    bus.io_i = 1'b0;
    step(3);
    chk("gl_state_503", 32'(bus.state_o), 3);
    step(1);
    chk("gl_state_504", 32'(bus.state_o), 4);
    chk("gl_active_504", 32'(bus.active), 1);
    bus.io_i = 1'b1;

    // Card removal in ACTIVE.
    step(10);
    bus.card_inserted = 1'b0;
    step(1);
    chk("rm_rst_q1", 32'(bus.card_rst), 0);
    chk("rm_grant_q1", 32'(bus.io_grant), 1);
    step(1);
    chk("rm_rst_q2", 32'(bus.card_rst), 1);
    chk("rm_grant_q2", 32'(bus.io_grant), 0);
    chk("rm_active_q2", 32'(bus.active), 0);
    step(1);
    chk("rm_state_q3", 32'(bus.state_o), 5);
    chk("rm_err_q3", 32'(bus.err_removed), 1);
    chk("rm_rst_q3", 32'(bus.card_rst), 1);
    step(16);
    chk("rm_clk_16", 32'(bus.card_clk_en), 0);
    step(32);
    chk("rm_state_48", 32'(bus.state_o), 0);
    chk("rm_pwr_48", 32'(bus.card_power_en), 0);
    chk("rm_err_sticky", 32'(bus.err_removed), 1);

    // Asynchronous reset while in CLKON.
    bus.card_inserted = 1'b1;
    step(3);
    pulse_start();
    step(259);
    chk("ar_state_clkon", 32'(bus.state_o), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", 32'(bus.state_o), 0);
    chk("ar_pwr", 32'(bus.card_power_en), 0);
    chk("ar_oe", 32'(bus.card_oe), 0);
    chk("ar_clk", 32'(bus.card_clk_en), 0);
    chk("ar_card_rst", 32'(bus.card_rst), 1);
    chk("ar_grant", 32'(bus.io_grant), 0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    pulse_start();
    chk("ar_restart_state", 32'(bus.state_o), 1);
    chk("ar_restart_pwr", 32'(bus.card_power_en), 1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc_session_ctrl.md
Name: sc_session_ctrl

Overview:
- Sequences the smartcard contact interface through ISO7816-3 cold activation, ATR detection and deactivation.
- Gates card power, output enable, card clock and card reset.
- Grants the I/O line to the USB pass-through path only once a valid ATR start bit has been seen.
- Sits between the card-insert switch / host control bits and the card pins, clocked by the card clock `clk` (3.571 MHz), so every count is in card clock cycles.

Parameters:
- CNT_W, 16, width of the shared delay counter; must hold ATR_MAX.
- T_PWR, 256, cycles from power enable to clock start.
- T_RST, 512, cycles the clock runs with reset held before reset release (ISO minimum 400).
- ATR_MIN, 400, cycles after reset release before an I/O falling edge counts as the ATR start.
- ATR_MAX, 40000, cycles after reset release by which the ATR start must appear.
- T_STEP, 16, spacing in cycles between deactivation steps.

Ports:
- clk  in  1  card clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- card_inserted  in  1  raw card-present switch, asynchronous.
- start_i  in  1  single-cycle activation request.
- stop_i  in  1  single-cycle deactivation request.
- io_i  in  1  raw card I/O line level, asynchronous.
- card_power_en  out  1  card VCC enable.
- card_oe  out  1  card level-shifter output enable.
- card_clk_en  out  1  enable to the card clock ODDR.
- card_rst  out  1  card reset, 1 = held in reset.
- io_grant  out  1  1 = pass-through may drive/observe card I/O.
- active  out  1  session established.
- err_timeout  out  1  sticky: no ATR by ATR_MAX.
- err_removed  out  1  sticky: card removed while not IDLE.
- state_o  out  3  current FSM state encoding.

Behaviour:
- Reset values: all outputs 0 except card_rst=1; state IDLE; counter 0; synchronisers cleared to the idle I/O level (1) and not-inserted (0).
- Input synchronisation: card_inserted and io_i each pass through a 2-flop synchroniser.
- io falling edge = sync value 1 on the previous cycle, 0 on the current cycle; 3-cycle latency from pin to edge pulse.
- Counter: reloads to 0 on every state entry and increments each cycle in timed states. A state's dwell of T_X means a transition on the cycle count==T_X-1.
- IDLE:
  - start_i with synced card present -> PWR; clears err_timeout and err_removed.
  - start_i with no card is ignored.
- PWR: card_power_en=1, card_oe=1. After T_PWR -> CLKON.
- CLKON: additionally card_clk_en=1; card_rst stays 1. After T_RST -> ATRW.
- ATRW: card_rst=0.
  - io falling edge with count >= ATR_MIN -> ACTIVE.
  - Edges with count < ATR_MIN are ignored.
  - count == ATR_MAX-1 with no valid edge -> set err_timeout, -> DEACT.
- ACTIVE: active=1, io_grant=1; rails as in ATRW. stop_i -> DEACT.
- DEACT: io_grant=0, active=0.
  - Entry cycle: card_rst=1.
  - After T_STEP: card_clk_en=0.
  - After 2*T_STEP: card_oe=0.
  - After 3*T_STEP: card_power_en=0, -> IDLE.
- Card removal (synced card_inserted=0) in any state other than IDLE or DEACT:
  - set err_removed;
  - force card_rst=1, io_grant=0, active=0 that same cycle;
  - -> DEACT with counter reset.
  - Removal has highest priority over start_i, stop_i, io edge and timeout in the same cycle.
- stop_i in PWR, CLKON or ATRW also -> DEACT. In IDLE or DEACT it is ignored.
- start_i in any state other than IDLE is ignored; no queuing.
- All outputs are registered. State-driven outputs change the cycle after the triggering event, except the removal override, which is combinational from the synced signal.
- Asynchronous rst mid-session returns immediately to reset values, with power dropped at once. No graceful sequence is required.
- state_o encoding: IDLE=0, PWR=1, CLKON=2, ATRW=3, ACTIVE=4, DEACT=5. Encodings 6 and 7 are unreachable and recover to DEACT.

Decomposition:
- Package sc_session_pkg holds:
  - the state enumeration and its encodings;
  - default timing constants (T_PWR, T_RST, ATR_MIN, ATR_MAX, T_STEP);
  - CNT_W.
- One sub-module, sc_sync_edge: 2-flop synchroniser with a registered falling-edge pulse output and a parameterised reset level. It is instantiated twice:
  - io_i, edge output used;
  - card_inserted, level output only.

Test Plan:
- Card present, start_i, ATR falling edge 1000 cycles after reset release:
  - card_power_en at +1; card_clk_en at +257; card_rst=0 at +769;
  - active=1 and io_grant=1 four cycles after the edge; state_o=4.
- Glitch edge at 100 cycles after release, real edge at 500 -> 100 ignored; ACTIVE entered from the 500 edge only.
- No ATR -> err_timeout=1 at release+40000; deactivation steps 16 cycles apart; state_o=0 at +48; card_rst=1 throughout.
- In ACTIVE, pull card_inserted low:
  - card_rst=1 and io_grant=0 within 3 cycles of the pin change;
  - err_removed=1; full DEACT sequence follows.
- stop_i in ACTIVE -> ordered deactivation: rst, clk off at +16, oe off at +32, power off at +48. Then start_i with no card -> stays IDLE.
- Assert rst while in CLKON -> all outputs at reset values within one cycle, card_rst=1; after release, start_i re-runs activation from PWR.
